// File: rtl/risc_debug_probe_if.sv
// Core-side bus of the debug probe: the clock enable going to the core and the
// per-instruction signals coming back from it.
interface risc_debug_probe_if;
  logic        core_ce;
  logic        core_retire;
  logic [31:0] core_pc;
  logic [31:0] core_instruction;
  logic [31:0] core_alu_result;
  logic [31:0] core_reg_data1;
  logic [31:0] core_reg_data2;
  logic [31:0] core_mem_data;

  // master = the RISC-V core, slave = the probe that gates it
  modport master (
    input  core_ce,
    output core_retire, core_pc, core_instruction, core_alu_result,
           core_reg_data1, core_reg_data2, core_mem_data
  );

  modport slave (
    output core_ce,
    input  core_retire, core_pc, core_instruction, core_alu_result,
           core_reg_data1, core_reg_data2, core_mem_data
  );
endinterface

// File: rtl/risc_debug_probe.sv
// Hardware debug probe for the RISC-V core: run/halt/single-step clock gating,
// per-retire snapshot of core signals and a ring buffer of recently retired PCs.

// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module risc_debug_probe_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic sw0,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (sw0) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
endmodule

module risc_debug_probe #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TRACE_DEPTH     = 16,
  parameter int STEP_TIMEOUT    = 255
) (
  input  logic                           clock,
  input  logic                           sw0,
  input  logic                           run_sw,
  input  logic                           step_btn,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_sel,
  risc_debug_probe_if.slave              core,
  output logic [31:0]                    pc,
  output logic [31:0]                    instruction,
  output logic [31:0]                    alu_result,
  output logic [31:0]                    reg_data1,
  output logic [31:0]                    reg_data2,
  output logic [31:0]                    mem_data,
  output logic [31:0]                    clock_counter,
  output logic [31:0]                    trace_pc,
  output logic                           halted,
  output logic                           step_timeout
);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int SW = $clog2(STEP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_step_cnt;
  logic [SW-1:0] w_step_cnt_nxt;
  logic          w_timeout_set;
  logic          r_core_ce;
  logic          r_halted;
  logic          r_step_timeout;

  logic          w_run_db;
  logic          w_step_db;
  logic          r_step_db_q;
  logic          w_step_pulse;
  logic          w_capture;

  logic [31:0]   r_pc;
  logic [31:0]   r_instruction;
  logic [31:0]   r_alu_result;
  logic [31:0]   r_reg_data1;
  logic [31:0]   r_reg_data2;
  logic [31:0]   r_mem_data;
  logic [31:0]   r_clock_counter;

  logic [31:0]   r_trace [TRACE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_rd_idx;
  logic [31:0]   r_trace_pc;

  risc_debug_probe_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clock   (clock),
    .sw0     (sw0),
    .i_raw   (run_sw),
    .o_level (w_run_db)
  );

  risc_debug_probe_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock   (clock),
    .sw0     (sw0),
    .i_raw   (step_btn),
    .o_level (w_step_db)
  );

  assign w_step_pulse = w_step_db & ~r_step_db_q;
  assign w_capture    = r_core_ce & core.core_retire;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_timeout_set  = 1'b0;
    unique case (r_state)
      ST_HALT: begin
        if (w_run_db) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_pulse) begin
          w_state_nxt    = ST_STEP;
          w_step_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!w_run_db) w_state_nxt = ST_HALT;
      end
      ST_STEP: begin
        // A retire on the last allowed cycle still counts as a clean step.
        w_step_cnt_nxt = r_step_cnt + 1'b1;
        if (w_capture) begin
          w_state_nxt = ST_HALT;
        end else if (r_step_cnt == SW'(STEP_TIMEOUT - 1)) begin
          w_state_nxt   = ST_HALT;
          w_timeout_set = 1'b1;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sw0) begin
      r_state        <= ST_HALT;
      r_step_cnt     <= '0;
      r_core_ce      <= 1'b0;
      r_halted       <= 1'b1;
      r_step_timeout <= 1'b0;
      r_step_db_q    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_step_cnt     <= w_step_cnt_nxt;
      r_core_ce      <= (w_state_nxt != ST_HALT);
      r_halted       <= (w_state_nxt == ST_HALT);
      r_step_timeout <= r_step_timeout | w_timeout_set;
      r_step_db_q    <= w_step_db;
    end
  end

  always_ff @(posedge clock) begin
    if (sw0) begin
      r_pc            <= '0;
      r_instruction   <= '0;
      r_alu_result    <= '0;
      r_reg_data1     <= '0;
      r_reg_data2     <= '0;
      r_mem_data      <= '0;
      r_clock_counter <= '0;
    end else begin
      if (w_capture) begin
        r_pc          <= core.core_pc;
        r_instruction <= core.core_instruction;
        r_alu_result  <= core.core_alu_result;
        r_reg_data1   <= core.core_reg_data1;
        r_reg_data2   <= core.core_reg_data2;
        r_mem_data    <= core.core_mem_data;
      end
      if (r_core_ce) r_clock_counter <= r_clock_counter + 32'd1;
    end
  end

  // Newest entry sits just behind the write pointer; modulo falls out of the PW-bit width.
  assign w_rd_idx = r_wr_ptr - PW'(1) - trace_sel;

  // NOTE: the trace array is reset explicitly because unwritten entries must read as zero.
  always_ff @(posedge clock) begin
    if (sw0) begin
      for (int i = 0; i < TRACE_DEPTH; i++) r_trace[i] <= '0;
      r_wr_ptr   <= '0;
      r_trace_pc <= '0;
    end else begin
      r_trace_pc <= r_trace[w_rd_idx];
      if (w_capture) begin
        r_trace[r_wr_ptr] <= core.core_pc;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
    end
  end

  assign core.core_ce  = r_core_ce;
  assign pc            = r_pc;
  assign instruction   = r_instruction;
  assign alu_result    = r_alu_result;
  assign reg_data1     = r_reg_data1;
  assign reg_data2     = r_reg_data2;
  assign mem_data      = r_mem_data;
  assign clock_counter = r_clock_counter;
  assign trace_pc      = r_trace_pc;
  assign halted        = r_halted;
  assign step_timeout  = r_step_timeout;
endmodule

// File: tb/tb_risc_debug_probe.sv
// Self-checking bench for risc_debug_probe: the bench plays the core, and a
// transaction-level model (last snapshot, PC history queue) predicts the outputs.
module tb_risc_debug_probe;
  localparam int DEB  = 4;
  localparam int TD   = 4;
  localparam int TO   = 8;
  localparam int SELW = 2;

  logic            clock = 1'b0;
  logic            sw0 = 1'b1;
  logic            run_sw = 1'b0;
  logic            step_btn = 1'b0;
  logic [SELW-1:0] trace_sel = '0;
  logic [31:0]     pc, instruction, alu_result, reg_data1, reg_data2, mem_data;
  logic [31:0]     clock_counter, trace_pc;
  logic            halted, step_timeout;

  risc_debug_probe_if core_if ();

  risc_debug_probe #(
    .DEBOUNCE_CYCLES (DEB),
    .TRACE_DEPTH     (TD),
    .STEP_TIMEOUT    (TO)
  ) dut (
    .clock         (clock),
    .sw0           (sw0),
    .run_sw        (run_sw),
    .step_btn      (step_btn),
    .trace_sel     (trace_sel),
    .core          (core_if.slave),
    .pc            (pc),
    .instruction   (instruction),
    .alu_result    (alu_result),
    .reg_data1     (reg_data1),
    .reg_data2     (reg_data2),
    .mem_data      (mem_data),
    .clock_counter (clock_counter),
    .trace_pc      (trace_pc),
    .halted        (halted),
    .step_timeout  (step_timeout)
  );

  always #10 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: last captured values, number of enabled cycles, PC history (newest first)
  logic [31:0] exp_snap [6];
  int          ce_total;
  logic [31:0] trace_q [$];

  function automatic logic [31:0] exp_trace(input int sel);
    return (sel < trace_q.size()) ? trace_q[sel] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) exp_snap[i] = '0;
    ce_total = 0;
    trace_q.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One core cycle: present retire/values, advance a clock, update the model.
  task automatic cycle(input logic ret, input logic [31:0] pcv);
    logic [31:0] v [6];
    logic        cap;
    v[0] = pcv;
    for (int i = 1; i < 6; i++) v[i] = $urandom;
    core_if.core_retire      = ret;
    core_if.core_pc          = v[0];
    core_if.core_instruction = v[1];
    core_if.core_alu_result  = v[2];
    core_if.core_reg_data1   = v[3];
    core_if.core_reg_data2   = v[4];
    core_if.core_mem_data    = v[5];
    cap = (core_if.core_ce === 1'b1) && ret;
    if (core_if.core_ce === 1'b1) ce_total++;
    tick();
    if (sw0) begin
      model_reset();
    end else if (cap) begin
      exp_snap = v;
      trace_q.push_front(pcv);
      if (trace_q.size() > TD) void'(trace_q.pop_back());
    end
  endtask

  task automatic test_reset();
    sw0 = 1'b1;
    cycle(1'b0, 32'h0);
    cycle(1'b0, 32'h0);
    sw0 = 1'b0;
    repeat (20) cycle(1'b0, 32'h0);
    total_cnt++;
    if (halted !== 1'b1) $display("FAIL reset_halted: got %b expected 1", halted);
    else pass_cnt++;
    total_cnt++;
    if (core_if.core_ce !== 1'b0) $display("FAIL reset_core_ce: got %b expected 0", core_if.core_ce);
    else pass_cnt++;
    total_cnt++;
    if (clock_counter !== 32'h0) $display("FAIL reset_counter: got %h expected 0", clock_counter);
    else pass_cnt++;
    total_cnt++;
    if (step_timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", step_timeout);
    else pass_cnt++;
    total_cnt++;
    if ({pc, instruction, alu_result, reg_data1, reg_data2, mem_data} !== 192'h0)
      $display("FAIL reset_snapshot: got %h expected 0",
               {pc, instruction, alu_result, reg_data1, reg_data2, mem_data});
    else pass_cnt++;
    for (int s = 0; s < TD; s++) begin
      trace_sel = SELW'(s);
      cycle(1'b0, 32'h0);
      total_cnt++;
      if (trace_pc !== 32'h0) $display("FAIL reset_trace%0d: got %h expected 0", s, trace_pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_run();
    int lat;
    int fall;
    int k;
    logic ret;
    lat = 0;
    run_sw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_ce === 1'b1) break;
      cycle(1'b0, 32'h0);
      lat++;
    end
    total_cnt++;
    if (core_if.core_ce !== 1'b1 || lat < 6 || lat > 7)
      $display("FAIL run_latency: got %0d cycles (ce=%b) expected 6..7", lat, core_if.core_ce);
    else pass_cnt++;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      ret = (i % 3 == 2);
      cycle(ret, 32'h1000 + 32'(4 * k));
      if (ret) begin
        total_cnt++;
        if (pc !== 32'h1000 + 32'(4 * k) || instruction !== exp_snap[1] || mem_data !== exp_snap[5])
          $display("FAIL run_pc%0d: got %h/%h expected %h/%h", k, pc, instruction,
                   32'h1000 + 32'(4 * k), exp_snap[1]);
        else pass_cnt++;
        k++;
      end
    end
    run_sw = 1'b0;
    fall = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_ce !== 1'b1) break;
      cycle(1'b0, 32'h0);
      fall++;
    end
    total_cnt++;
    if (core_if.core_ce !== 1'b0 || halted !== 1'b1 || fall != lat)
      $display("FAIL run_halt: got fall %0d ce %b halted %b expected fall %0d ce 0 halted 1",
               fall, core_if.core_ce, halted, lat);
    else pass_cnt++;
    total_cnt++;
    if (clock_counter !== 32'(ce_total) || ce_total != 30 + lat)
      $display("FAIL run_counter: got %0d (model %0d) expected %0d", clock_counter, ce_total, 30 + lat);
    else pass_cnt++;
  endtask

  task automatic test_step();
    int start;
    logic ret;
    logic [31:0] pcv;
    start = ce_total;
    for (int i = 0; i < 60; i++) begin
      step_btn = (i < 2) || (i >= 4 && i < 6) || (i >= 8 && i < 20);
      if (core_if.core_ce === 1'b1) begin
        ret = (ce_total - start == 2);
        pcv = 32'h2000;
      end else begin
        ret = 1'($urandom_range(0, 1));
        pcv = $urandom;
      end
      cycle(ret, pcv);
    end
    total_cnt++;
    if (ce_total - start != 3) $display("FAIL step_ce_cycles: got %0d expected 3", ce_total - start);
    else pass_cnt++;
    total_cnt++;
    if (pc !== 32'h2000 || alu_result !== exp_snap[2])
      $display("FAIL step_pc: got %h expected 00002000", pc);
    else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b1 || step_timeout !== 1'b0)
      $display("FAIL step_halted: got halted %b timeout %b expected 1 0", halted, step_timeout);
    else pass_cnt++;
    total_cnt++;
    if (clock_counter !== 32'(start + 3))
      $display("FAIL step_counter: got %0d expected %0d", clock_counter, start + 3);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int start;
    start = ce_total;
    for (int i = 0; i < 60; i++) begin
      step_btn = (i < 10);
      cycle((core_if.core_ce === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1)), $urandom);
    end
    total_cnt++;
    if (ce_total - start != TO) $display("FAIL timeout_ce_cycles: got %0d expected %0d", ce_total - start, TO);
    else pass_cnt++;
    total_cnt++;
    if (step_timeout !== 1'b1 || halted !== 1'b1)
      $display("FAIL timeout_flag: got timeout %b halted %b expected 1 1", step_timeout, halted);
    else pass_cnt++;
    total_cnt++;
    if (clock_counter !== 32'(start + TO))
      $display("FAIL timeout_counter: got %0d expected %0d", clock_counter, start + TO);
    else pass_cnt++;
  endtask

  task automatic test_trace();
    logic [31:0] lit [4];
    int saved;
    lit[0] = 32'h24; lit[1] = 32'h20; lit[2] = 32'h1C; lit[3] = 32'h18;
    run_sw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_ce === 1'b1) break;
      cycle(1'b0, 32'h0);
    end
    total_cnt++;
    if (core_if.core_ce !== 1'b1) $display("FAIL trace_run_start: got ce %b expected 1", core_if.core_ce);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) cycle(1'b1, 32'h10 + 32'(4 * k));
    run_sw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (core_if.core_ce !== 1'b1) break;
      cycle(1'b0, 32'h0);
    end
    for (int s = 0; s < TD; s++) begin
      trace_sel = SELW'(s);
      cycle(1'b0, 32'h0);
      total_cnt++;
      if (trace_pc !== lit[s]) $display("FAIL trace_sel%0d: got %h expected %h", s, trace_pc, lit[s]);
      else pass_cnt++;
    end
    saved = ce_total;
    repeat (10) cycle(1'($urandom_range(0, 1)), $urandom);
    total_cnt++;
    if (clock_counter !== 32'(saved) || core_if.core_ce !== 1'b0)
      $display("FAIL trace_frozen: got %0d ce %b expected %0d ce 0", clock_counter, core_if.core_ce, saved);
    else pass_cnt++;
    total_cnt++;
    if (pc !== 32'h24 || step_timeout !== 1'b1)
      $display("FAIL trace_hold: got pc %h timeout %b expected 00000024 1", pc, step_timeout);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int n_on;
    int sel;
    logic [31:0] e;
    for (int r = 0; r < 4; r++) begin
      n_on = $urandom_range(10, 30);
      for (int i = 0; i < n_on + 20; i++) begin
        run_sw    = (i < n_on);
        sel       = $urandom_range(0, TD - 1);
        trace_sel = SELW'(sel);
        e         = exp_trace(sel);
        cycle(1'($urandom_range(0, 1)), $urandom);
        total_cnt++;
        if (trace_pc !== e) $display("FAIL rand%0d_trace c%0d sel%0d: got %h expected %h", r, i, sel, trace_pc, e);
        else pass_cnt++;
      end
      total_cnt++;
      if ({pc, instruction, alu_result, reg_data1, reg_data2, mem_data} !==
          {exp_snap[0], exp_snap[1], exp_snap[2], exp_snap[3], exp_snap[4], exp_snap[5]})
        $display("FAIL rand%0d_snapshot: got %h expected %h", r,
                 {pc, instruction, alu_result, reg_data1, reg_data2, mem_data},
                 {exp_snap[0], exp_snap[1], exp_snap[2], exp_snap[3], exp_snap[4], exp_snap[5]});
      else pass_cnt++;
      total_cnt++;
      if (clock_counter !== 32'(ce_total) || halted !== 1'b1 || core_if.core_ce !== 1'b0)
        $display("FAIL rand%0d_counter: got %0d halted %b expected %0d halted 1", r, clock_counter, halted, ce_total);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_step();
    int start;
    start = ce_total;
    for (int i = 0; i < 40; i++) begin
      step_btn = (i < 8);
      if (ce_total - start == 3) break;
      cycle(1'b0, 32'h0);
    end
    total_cnt++;
    if (core_if.core_ce !== 1'b1) $display("FAIL mid_step_active: got ce %b expected 1", core_if.core_ce);
    else pass_cnt++;
    step_btn = 1'b0;
    sw0 = 1'b1;
    cycle(1'b0, 32'h0);
    sw0 = 1'b0;
    total_cnt++;
    if (core_if.core_ce !== 1'b0 || halted !== 1'b1 || step_timeout !== 1'b0)
      $display("FAIL mid_reset_state: got ce %b halted %b timeout %b expected 0 1 0",
               core_if.core_ce, halted, step_timeout);
    else pass_cnt++;
    total_cnt++;
    if ({pc, instruction, alu_result, reg_data1, reg_data2, mem_data, clock_counter, trace_pc} !== 256'h0)
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {pc, instruction, alu_result, reg_data1, reg_data2, mem_data, clock_counter, trace_pc});
    else pass_cnt++;
    repeat (20) cycle(1'b0, 32'h0);
    total_cnt++;
    if (core_if.core_ce !== 1'b0 || clock_counter !== 32'h0)
      $display("FAIL mid_reset_idle: got ce %b counter %0d expected 0 0", core_if.core_ce, clock_counter);
    else pass_cnt++;
  endtask

  initial begin
    core_if.core_retire      = 1'b0;
    core_if.core_pc          = '0;
    core_if.core_instruction = '0;
    core_if.core_alu_result  = '0;
    core_if.core_reg_data1   = '0;
    core_if.core_reg_data2   = '0;
    core_if.core_mem_data    = '0;
    model_reset();
    test_reset();
    test_run();
    test_step();
    test_timeout();
    test_trace();
    test_random();
    test_reset_mid_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/risc_debug_probe.md
Name: risc_debug_probe

Overview:
- Real-hardware source for the RISC-V debug display. It replaces the simulated data generator.
- Sits between the RISC-V core and `risc_debug_display`.
- Gates the core with a clock enable: run, halt and single-step, driven by board switches and a button.
- Snapshots the core signals on each retired instruction and keeps a ring buffer of recent PCs for the display.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before a switch/button level is accepted (10 ms at 50 MHz).
- TRACE_DEPTH, 16: PC trace ring-buffer entries; must be a power of 2, ≥2.
- STEP_TIMEOUT, 255: max core-enabled cycles in one step before it is forced back to halt.

Ports:
- clock  in  1  50 MHz system clock, single clock domain
- sw0  in  1  reset, synchronous, active-high
- run_sw  in  1  raw switch: 1 = free run, 0 = halt
- step_btn  in  1  raw pushbutton: a press executes one instruction while halted
- core_retire  in  1  core pulses high for one cycle when an instruction retires; ignored when core_ce=0
- core_pc, core_instruction, core_alu_result, core_reg_data1, core_reg_data2, core_mem_data  in  32 each  live core signals
- trace_sel  in  $clog2(TRACE_DEPTH)  0 = most recent PC, 1 = previous PC, and so on
- core_ce  out  1  clock enable to the core
- pc, instruction, alu_result, reg_data1, reg_data2, mem_data  out  32 each  snapshot of the last retired instruction
- clock_counter  out  32  count of core-enabled cycles
- trace_pc  out  32  selected trace entry
- halted  out  1  high in HALT state
- step_timeout  out  1  sticky; set when a step times out

Behaviour:
- Reset (sw0=1 at posedge clock) has priority over all other activity:
  - state=HALT, core_ce=0, halted=1, step_timeout=0.
  - All 32-bit outputs, trace buffer, write pointer and counters = 0.
  - Debounced levels = 0.
  - Reset mid-STEP: core_ce=0 on the next cycle.
- Input conditioning:
  - run_sw and step_btn each pass through a 2-flop synchronizer.
  - A per-input counter accepts a new debounced level after DEBOUNCE_CYCLES consecutive cycles of a synchronized value differing from the current debounced level; any bounce restarts the count.
  - A rising edge of debounced step gives a 1-cycle step_pulse.
- FSM (Moore; core_ce and halted are registered and decoded from the state):
  - HALT (core_ce=0):
    - run_db=1 → RUN.
    - Else step_pulse → STEP; clear step count.
  - RUN (core_ce=1):
    - run_db=0 → HALT.
    - step_pulse is ignored.
  - STEP (core_ce=1):
    - Capture (core_retire=1 with core_ce=1) → HALT.
    - Step count reaches STEP_TIMEOUT → HALT and set step_timeout.
    - run_db rising during STEP: the step completes to HALT first, then HALT→RUN on a following cycle.
  - step_timeout clears only on reset.
- Snapshot:
  - A capture cycle is core_ce=1 and core_retire=1.
  - The six core values are registered onto the six outputs; new values are visible the cycle after capture.
  - Outputs hold at all other times.
- clock_counter: +1 every cycle core_ce=1; wraps 0xFFFFFFFF→0; holds when halted.
- Trace buffer:
  - On capture, core_pc is written at wr_ptr and wr_ptr increments modulo TRACE_DEPTH (wrap overwrites the oldest entry).
  - Read: trace_pc = buf[(wr_ptr-1-trace_sel) mod TRACE_DEPTH], registered, 1-cycle latency.
  - Capture and read in the same cycle: the read returns the pre-write contents.
  - Entries never written read 0.

Test Plan (DEBOUNCE_CYCLES=4, TRACE_DEPTH=4, STEP_TIMEOUT=8):
- Reset then idle 20 cycles → halted=1, core_ce=0, pc=0, clock_counter=0, trace_pc=0 for every trace_sel.
- Hold run_sw=1 and retire every 3rd cycle with core_pc=0x1000,0x1004,… → core_ce rises 6–7 cycles after run_sw (2-flop sync + 4-cycle debounce + state/output register, off-by-one allowed); clock_counter increments each core_ce cycle; pc tracks the last retired PC one cycle after each retire.
- Halted; press step_btn with 2-cycle bounce glitches; core_retire on the 3rd enabled cycle with core_pc=0x2000 → exactly one STEP; core_ce high for exactly 3 cycles; pc=0x2000; halted=1 again; clock_counter +3.
- Step with core_retire held 0 → core_ce high for exactly 8 cycles, then HALT; step_timeout=1 and it stays 1 across later runs until sw0.
- Retire 6 PCs 0x10,0x14,…,0x24 → trace_sel=0 gives 0x24, 1 gives 0x20, 3 gives 0x18 (wrap verified); drop run_sw → clock_counter frozen.
- Assert sw0 one cycle during STEP → next cycle core_ce=0, all outputs 0, state HALT.
